fetch_stage: RTL and testbench

Instruction fetch stage sitting directly downstream of the PC generation stage and upstream of decode. It issues one instruction-memory read per accepted PC and tracks in-flight reads in a small in-order buffer. It delivers fetched instructions with their PCs to decode, and drives the PC generator's advance/ready input. It also discards stale responses after a pipeline flush (exception or misprediction redirect).

---
 rtl/mmm_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 61 ++++++
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Core-wide widths, boot vector and fetch-stage types.
package mmm_pkg;

    localparam int XLEN        = 32;
    localparam int ILEN        = 32;
    localparam int FETCH_DEPTH = 4;

    localparam logic [XLEN-1:0] BOOT_PC = 32'h0000_1000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            fault;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: entries are allocated at issue, filled by responses, popped by decode.
// Latency: a fill is visible at the head on the cycle after it is written.
// Backpressure: none internally; the owner never allocates into a full buffer.
module fetch_buffer
    import mmm_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear,
    input  logic             alloc,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             fill,
    input  logic [ILEN-1:0]  fill_instr,
    input  logic             fill_err,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [AW:0]      occupied,
    output logic [AW:0]      unfilled
);

    fetch_entry_t entries [DEPTH];

    // One extra pointer bit distinguishes full from empty, so both counts come from subtraction.
    logic [AW:0] alloc_ptr;
    logic [AW:0] fill_ptr;
    logic [AW:0] head_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                entries[alloc_ptr[AW-1:0]] <= '{pc: alloc_pc, instr: '0, fault: 1'b0, filled: 1'b0};
                alloc_ptr <= alloc_ptr + 1'b1;
            end
            if (fill) begin
                entries[fill_ptr[AW-1:0]].instr  <= fill_err ? '0 : fill_instr;
                entries[fill_ptr[AW-1:0]].fault  <= fill_err;
                entries[fill_ptr[AW-1:0]].filled <= 1'b1;
                fill_ptr <= fill_ptr + 1'b1;
            end
            if (pop) begin
                entries[head_ptr[AW-1:0]].filled <= 1'b0;
                head_ptr <= head_ptr + 1'b1;
            end
        end
    end

    assign head     = entries[head_ptr[AW-1:0]];
    assign occupied = alloc_ptr - head_ptr;
    assign unfilled = alloc_ptr - fill_ptr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one memory read per accepted PC, in-order delivery of (pc, instr, fault) to decode.
// Latency: response in cycle N is offered to decode in cycle N+1; no bypass.
// Backpressure: issue stalls once buffered plus discarded reads reach DEPTH; decode stalls via decode_ready_i.
module fetch_stage
    import mmm_pkg::*;
#(
    parameter int XLEN  = mmm_pkg::XLEN,
    parameter int ILEN  = mmm_pkg::ILEN,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             pc_ready_o,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic [XLEN-1:0]  mem_addr_o,
    input  logic             mem_resp_valid_i,
    input  logic [ILEN-1:0]  mem_resp_data_i,
    input  logic             mem_resp_err_i,
    output logic             instr_valid_o,
    input  logic             decode_ready_i,
    output logic [ILEN-1:0]  instr_o,
    output logic [XLEN-1:0]  instr_pc_o,
    output logic             instr_fault_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    fetch_entry_t head;
    logic [AW:0]  occupied;
    logic [AW:0]  unfilled;
    logic [AW:0]  discard_cnt;
    logic [CW-1:0] inflight;
    logic         accept;
    logic         fill;
    logic         pop;

    // Discarded reads still occupy memory slots, so they count against the outstanding cap.
    assign inflight        = CW'(occupied) + CW'(discard_cnt);
    assign mem_req_valid_o = !rst_i && !flush_i && (inflight < CW'(DEPTH));
    assign mem_addr_o      = pc_i;
    assign accept          = mem_req_valid_o && mem_req_ready_i;
    assign pc_ready_o      = !rst_i && (flush_i || accept);

    assign instr_valid_o   = !rst_i && !flush_i && head.filled;
    assign pop             = instr_valid_o && decode_ready_i;
    assign instr_o         = head.instr;
    assign instr_pc_o      = head.pc;
    assign instr_fault_o   = head.fault;

    assign fill = !rst_i && !flush_i && mem_resp_valid_i && (discard_cnt == '0);

    // On flush, every read still owed becomes a discard, less the one answered this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            discard_cnt <= '0;
        end else if (flush_i) begin
            discard_cnt <= discard_cnt + unfilled - (AW+1)'(mem_resp_valid_i);
        end else if (mem_resp_valid_i && (discard_cnt != '0)) begin
            discard_cnt <= discard_cnt - 1'b1;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear      (flush_i),
        .alloc      (accept),
        .alloc_pc   (pc_i),
        .fill       (fill),
        .fill_instr (mem_resp_data_i),
        .fill_err   (mem_resp_err_i),
        .pop        (pop),
        .head       (head),
        .occupied   (occupied),
        .unfilled   (unfilled)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: queue-based reference model checked every cycle plus literal checkpoints.
module tb_fetch_stage;
    import mmm_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [31:0] pc_i;
    logic        pc_ready_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        mem_resp_err_i;
    logic        instr_valid_o;
    logic        decode_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_fault_o;

    always #5 clk_i = ~clk_i;

    fetch_stage #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .pc_i             (pc_i),
        .pc_ready_o       (pc_ready_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_err_i   (mem_resp_err_i),
        .instr_valid_o    (instr_valid_o),
        .decode_ready_i   (decode_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_fault_o    (instr_fault_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Knobs set by the directed sequence, applied at the next falling edge.
    logic        k_rst    = 1'b1;
    logic        k_flush  = 1'b0;
    logic        k_memrdy = 1'b1;
    logic        k_decrdy = 1'b1;
    logic [31:0] k_tgt    = 32'h0;
    int          k_lat    = 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
        logic        filled;
    } ment_t;
    typedef struct {
        logic [31:0] pc;
        int          due;
    } mreq_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
        int          at;
    } dlv_t;

    ment_t       mq[$];
    int          m_disc = 0;
    mreq_t       memq[$];
    int          last_due = 0;
    logic [31:0] pcg = BOOT_PC;
    dlv_t        dlv[$];
    int          acc_cnt = 0;
    int          acc_last = -1;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    function automatic logic err_of(input logic [31:0] pc);
        return pc == 32'h0000_3000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Driver, memory model, PC generator, reference model and per-cycle compare.
    logic        e_req, e_acc, e_ivld, e_pop, e_prdy, resp, r_err;
    logic [31:0] r_pc;
    int          nunf, fu, due;
    ment_t       ne;
    mreq_t       nr;
    dlv_t        nd;

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; pc_i = BOOT_PC; mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0; mem_resp_data_i = '0; mem_resp_err_i = 1'b0; decode_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            rst_i = k_rst; flush_i = k_flush; mem_req_ready_i = k_memrdy;
            decode_ready_i = k_decrdy; pc_i = pcg;
            resp = 1'b0; r_pc = '0; r_err = 1'b0;
            if (!k_rst && memq.size() > 0) begin
                if (memq[0].due <= cyc) begin
                    resp  = 1'b1;
                    r_pc  = memq[0].pc;
                    r_err = err_of(r_pc);
                end
            end
            mem_resp_valid_i = resp;
            mem_resp_data_i  = resp ? instr_of(r_pc) : 32'h0;
            mem_resp_err_i   = r_err;
            #1;
            nunf = 0; fu = -1;
            foreach (mq[i]) begin
                if (!mq[i].filled) begin
                    nunf++;
                    if (fu < 0) fu = i;
                end
            end
            e_req  = !k_rst && !k_flush && (mq.size() + m_disc < DEPTH);
            e_acc  = e_req && k_memrdy;
            e_ivld = !k_rst && !k_flush && mq.size() > 0 && mq[0].filled;
            e_pop  = e_ivld && k_decrdy;
            e_prdy = !k_rst && (k_flush || e_acc);

            check("mem_req_valid", 32'(mem_req_valid_o), 32'(e_req));
            check("pc_ready", 32'(pc_ready_o), 32'(e_prdy));
            check("instr_valid", 32'(instr_valid_o), 32'(e_ivld));
            if (e_req) check("mem_addr", mem_addr_o, pcg);
            if (e_ivld) begin
                check("instr", instr_o, mq[0].instr);
                check("instr_pc", instr_pc_o, mq[0].pc);
                check("instr_fault", 32'(instr_fault_o), 32'(mq[0].fault));
            end

            if (instr_valid_o && decode_ready_i) begin
                nd = '{pc: instr_pc_o, instr: instr_o, fault: instr_fault_o, at: cyc};
                dlv.push_back(nd);
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                acc_cnt++;
                acc_last = cyc;
            end

            if (resp && m_disc == 0 && nunf == 0) begin
                $display("FAIL resp_without_request cyc=%0d", cyc);
                $fatal(1);
            end

            if (k_rst) begin
                mq.delete(); memq.delete(); m_disc = 0; pcg = BOOT_PC;
            end else begin
                if (resp) void'(memq.pop_front());
                if (k_flush) begin
                    m_disc = m_disc + nunf - (resp ? 1 : 0);
                    mq.delete();
                end else begin
                    if (resp) begin
                        if (m_disc > 0) begin
                            m_disc--;
                        end else begin
                            mq[fu].filled = 1'b1;
                            mq[fu].fault  = r_err;
                            mq[fu].instr  = r_err ? 32'h0 : instr_of(r_pc);
                        end
                    end
                    if (e_pop) void'(mq.pop_front());
                    if (e_acc) begin
                        ne = '{pc: pcg, instr: 32'h0, fault: 1'b0, filled: 1'b0};
                        mq.push_back(ne);
                    end
                end
                if (e_acc) begin
                    due = cyc + k_lat;
                    if (due <= last_due) due = last_due + 1;
                    nr = '{pc: pcg, due: due};
                    memq.push_back(nr);
                    last_due = due;
                end
                if (k_flush) pcg = k_tgt;
                else if (e_acc) pcg = pcg + 32'd4;
            end
            cyc++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        k_rst = 1'b1;
        wait_cyc(1);
        k_rst = 1'b0;
    endtask

    int t0, a0, a1, p;

    initial begin
        wait_cyc(3);
        check("rst_req_valid", 32'(mem_req_valid_o), 32'h0);
        check("rst_pc_ready", 32'(pc_ready_o), 32'h0);
        check("rst_instr_valid", 32'(instr_valid_o), 32'h0);
        check("rst_occupied", 32'(dut.occupied), 32'h0);

        // Streaming at full rate, 1-cycle memory.
        k_rst = 1'b0; t0 = cyc; dlv.delete();
        wait_cyc(8);
        check("a_deliveries", 32'(dlv.size() >= 3), 32'h1);
        if (dlv.size() >= 3) begin
            check("a0_pc", dlv[0].pc, 32'h0000_1000);
            check("a0_instr", dlv[0].instr, 32'h1000_EFFF);
            check("a0_cycle", 32'(dlv[0].at - t0), 32'd2);
            check("a1_pc", dlv[1].pc, 32'h0000_1004);
            check("a1_instr", dlv[1].instr, 32'h1004_EFFB);
            check("a1_cycle", 32'(dlv[1].at - t0), 32'd3);
            check("a2_pc", dlv[2].pc, 32'h0000_1008);
            check("a2_instr", dlv[2].instr, 32'h1008_EFF7);
            check("a2_cycle", 32'(dlv[2].at - t0), 32'd4);
        end

        // Decode stalled: outstanding cap, then one pop frees one slot.
        k_decrdy = 1'b0;
        pulse_reset();
        a0 = acc_cnt;
        wait_cyc(8);
        check("b_accepts_full", 32'(acc_cnt - a0), 32'd4);
        check("b_req_valid_full", 32'(mem_req_valid_o), 32'h0);
        check("b_pc_ready_full", 32'(pc_ready_o), 32'h0);
        k_decrdy = 1'b1; p = cyc;
        wait_cyc(1);
        k_decrdy = 1'b0; a1 = acc_cnt;
        wait_cyc(4);
        check("b_accepts_after_pop", 32'(acc_cnt - a1), 32'd1);
        check("b_accept_cycle", 32'(acc_last - p), 32'd1);

        // Flush with three slow reads outstanding.
        k_decrdy = 1'b1; k_lat = 5;
        pulse_reset();
        wait_cyc(3);
        k_flush = 1'b1; k_tgt = 32'h0000_2000;
        wait_cyc(1);
        k_flush = 1'b0;
        check("c_discard_after_flush", 32'(dut.discard_cnt), 32'd3);
        dlv.delete();
        wait_cyc(14);
        check("c_deliveries", 32'(dlv.size() >= 1), 32'h1);
        if (dlv.size() >= 1) begin
            check("c0_pc", dlv[0].pc, 32'h0000_2000);
            check("c0_instr", dlv[0].instr, 32'h2000_DFFF);
        end
        check("c_discard_drained", 32'(dut.discard_cnt), 32'd0);

        // Flush colliding with a response, then a faulting fetch at the redirect target.
        k_lat = 2; k_decrdy = 1'b0;
        pulse_reset();
        wait_cyc(3);
        k_flush = 1'b1; k_tgt = 32'h0000_3000;
        @(negedge clk_i);
        #2;
        check("d_head_filled", 32'(dut.head.filled), 32'h1);
        check("d_instr_valid_in_flush", 32'(instr_valid_o), 32'h0);
        check("d_pc_ready_in_flush", 32'(pc_ready_o), 32'h1);
        check("d_req_valid_in_flush", 32'(mem_req_valid_o), 32'h0);
        @(posedge clk_i);
        #1;
        k_flush = 1'b0;
        check("d_discard_after_flush", 32'(dut.discard_cnt), 32'd1);
        dlv.delete(); k_decrdy = 1'b1;
        wait_cyc(10);
        check("e_deliveries", 32'(dlv.size() >= 2), 32'h1);
        if (dlv.size() >= 2) begin
            check("e0_pc", dlv[0].pc, 32'h0000_3000);
            check("e0_fault", 32'(dlv[0].fault), 32'h1);
            check("e0_instr", dlv[0].instr, 32'h0);
            check("e1_pc", dlv[1].pc, 32'h0000_3004);
            check("e1_fault", 32'(dlv[1].fault), 32'h0);
            check("e1_instr", dlv[1].instr, 32'h3004_CFFB);
        end

        // Reset with two filled entries waiting.
        k_lat = 1; k_decrdy = 1'b0;
        pulse_reset();
        wait_cyc(2);
        k_memrdy = 1'b0;
        wait_cyc(3);
        check("f_occupied_before", 32'(dut.occupied), 32'd2);
        check("f_valid_before", 32'(instr_valid_o), 32'h1);
        k_memrdy = 1'b1;
        pulse_reset();
        @(negedge clk_i);
        #2;
        check("f_valid_after", 32'(instr_valid_o), 32'h0);
        check("f_occupied_after", 32'(dut.occupied), 32'd0);
        check("f_req_valid_after", 32'(mem_req_valid_o), 32'h1);
        check("f_addr_after", mem_addr_o, 32'h0000_1000);
        @(posedge clk_i);
        #1;
        k_decrdy = 1'b1;
        wait_cyc(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
